glitc_intercom_decoder: RTL
===========================

Name: glitc_intercom_decoder

Overview:
Receive-side word decoder for the GLITC-to-GLITC intercom link, in the sysclk domain directly after the four per-lane 4-bit DDR ISERDES.
- Undoes the optional lane inversion.
- Trains lane alignment on SYNC words by issuing per-lane bitslip pulses.
- Once locked, splits each 16-bit word into a command stream (cmd/cmd_dat) or a data stream (corr/power), mirroring the transmitter's {cmd,3'b111,cmd_dat} / {corr,power} framing.

Parameters:
INVERT, 0, 1 = lanes are polarity-swapped; the entire input word is complemented before any use.
SLIP_WAIT, 3, sysclk cycles to wait after a bitslip pulse before re-examining the word (range 1..15).
LOCK_COUNT, 16, consecutive SYNC words required in CONFIRM before LOCKED (range 1..255).
SYNC_TIMEOUT, 65535, cycles in LOCKED without a SYNC before lock is dropped (16-bit counter).

Ports:
sysclk_i  in  1  system clock; all logic is synchronous to its rising edge
rst_i  in  1  asynchronous, active-high reset
train_i  in  1  level; while high, forces the FSM to SEARCH
iserdes_dat_i  in  16  deserialized word; nibble k = lane k; bit 4k+3 = first bit received on lane k
locked_o  out  1  high in LOCKED only
bitslip_o  out  4  one-cycle bitslip pulse per lane (to ISERDES BITSLIP)
align_err_o  out  1  sticky; set when any lane exceeds 8 slips without a match; cleared by reset or train_i rising
sync_o  out  1  one-cycle pulse per SYNC word received while LOCKED
cmd_valid_o  out  1  one-cycle pulse; cmd_o/cmd_dat_o valid
cmd_o  out  5  command field, word[15:11]
cmd_dat_o  out  8  command data, word[7:0]
data_valid_o  out  1  one-cycle pulse; corr_o/power_o valid
corr_o  out  5  word[15:11]
power_o  out  11  word[10:0]

Behaviour:
- w = INVERT ? ~iserdes_dat_i : iserdes_dat_i. This is combinational; no extra register on the input.
- SYNC word is 16'h27ED (cmd 0x04, cmd_dat 0xED). Lane target nibbles: lane3=0x2, lane2=0x7, lane1=0xE, lane0=0xD.
- Command escape: w[10:8]==3'b111. The transmitter limits power to 0..0x6FF, so this field value is reserved for commands.
- Reset values: all outputs 0; FSM=SEARCH; all counters 0.
- SEARCH:
  - If w==SYNC, go to CONFIRM with lock counter = 1.
  - Otherwise, pulse bitslip_o[k] for every lane whose nibble mismatches, increment that lane's 4-bit slip count, and go to SLIP_WAIT.
  - A slip count reaching 9 sets align_err_o and clears all slip counts. Searching continues.
- SLIP_WAIT: count SLIP_WAIT cycles, ignoring w, then return to SEARCH. bitslip_o is 0 in this state.
- CONFIRM:
  - w==SYNC increments the lock counter. On reaching LOCK_COUNT, go to LOCKED and clear the slip counts and timeout counter.
  - Any non-SYNC word returns to SEARCH; no slip is issued that cycle.
- LOCKED:
  - Output pulses are registered, one cycle after w is presented (latency 1).
  - w[10:8]==3'b111: cmd_valid_o=1 with cmd_o/cmd_dat_o.
  - Otherwise: data_valid_o=1 with corr_o/power_o.
  - Exactly one of cmd_valid_o or data_valid_o pulses every LOCKED cycle.
  - w==SYNC additionally pulses sync_o alongside cmd_valid_o, and resets the timeout counter.
  - Timeout counter reaching SYNC_TIMEOUT goes to SEARCH. locked_o falls on the same edge; no valid pulse is issued that cycle.
- train_i high in any state: next state is SEARCH, and all counters and valids clear the next cycle. align_err_o clears on the train_i rising edge.
- Unused fields hold their last value when the corresponding valid is low.
- bitslip_o is never asserted in two consecutive cycles.

Test Plan:
1. Reset, then constant w=16'h27ED -> CONFIRM after 1 cycle; locked_o=1 after LOCK_COUNT=16 SYNC words; bitslip_o stays 0.
2. Lane1 presents 0xB (rotated 0xE), others correct -> single bitslip_o=4'b0010 pulse; after SLIP_WAIT=3 cycles with lane1 corrected to 0xE, lock is achieved.
3. Locked, w=16'h4F12 -> one cycle later cmd_valid_o=1, cmd_o=0x09, cmd_dat_o=0x12, data_valid_o=0.
4. Locked, w=16'h86FF -> data_valid_o=1, corr_o=0x10, power_o=0x6FF, cmd_valid_o=0.
5. INVERT=1, w=~16'h27ED continuously -> lock as in scenario 1; then locked with no SYNC for 65535 cycles -> locked_o falls and FSM returns to SEARCH.
6. Lane0 never matches for 9 slips -> align_err_o=1 (sticky); train_i pulse clears it; rst_i asserted mid-CONFIRM -> all outputs 0 immediately.

Source files
------------

// File: rtl/glitc_intercom_decoder.sv
// Receive-side word decoder for the GLITC intercom link: lane polarity undo,
// bitslip-based lane alignment on SYNC words, and command/data stream split.
module glitc_intercom_decoder #(
  parameter bit          INVERT       = 1'b0,
  parameter int unsigned SLIP_WAIT    = 3,
  parameter int unsigned LOCK_COUNT   = 16,
  parameter int unsigned SYNC_TIMEOUT = 65535
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic        train_i,
  input  logic [15:0] iserdes_dat_i,
  output logic        locked_o,
  output logic [3:0]  bitslip_o,
  output logic        align_err_o,
  output logic        sync_o,
  output logic        cmd_valid_o,
  output logic [4:0]  cmd_o,
  output logic [7:0]  cmd_dat_o,
  output logic        data_valid_o,
  output logic [4:0]  corr_o,
  output logic [10:0] power_o
);

  localparam logic [15:0] SYNC_WORD = 16'h27ED;
  localparam logic [3:0]  WAIT_LAST = 4'(SLIP_WAIT - 1);
  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_COUNT);
  localparam logic [15:0] TMO_LAST  = 16'(SYNC_TIMEOUT);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_SLIP    = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic [3:0][3:0] slip_cnt, slip_cnt_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [7:0]  lock_cnt, lock_cnt_nxt;
  logic [15:0] tmo_cnt, tmo_cnt_nxt;
  logic        train_d;

  logic        locked_nxt, align_err_nxt, sync_nxt, cmd_valid_nxt, data_valid_nxt;
  logic [3:0]  bitslip_nxt;
  logic [4:0]  cmd_nxt, corr_nxt;
  logic [7:0]  cmd_dat_nxt;
  logic [10:0] power_nxt;

  logic [15:0] w;
  logic        is_sync, is_cmd, slip_limit;

  assign w       = INVERT ? ~iserdes_dat_i : iserdes_dat_i;
  assign is_sync = (w == SYNC_WORD);
  assign is_cmd  = (w[10:8] == 3'b111);

  // Next-state, counter and output-pulse decode
  always_comb begin
    state_nxt      = state;
    slip_cnt_nxt   = slip_cnt;
    wait_cnt_nxt   = wait_cnt;
    lock_cnt_nxt   = lock_cnt;
    tmo_cnt_nxt    = tmo_cnt;
    align_err_nxt  = align_err_o;
    bitslip_nxt    = 4'd0;
    sync_nxt       = 1'b0;
    cmd_valid_nxt  = 1'b0;
    data_valid_nxt = 1'b0;
    cmd_nxt        = cmd_o;
    cmd_dat_nxt    = cmd_dat_o;
    corr_nxt       = corr_o;
    power_nxt      = power_o;
    slip_limit     = 1'b0;

    if (train_i) begin
      state_nxt     = ST_SEARCH;
      slip_cnt_nxt  = '0;
      wait_cnt_nxt  = 4'd0;
      lock_cnt_nxt  = 8'd0;
      tmo_cnt_nxt   = 16'd0;
      align_err_nxt = train_d ? align_err_o : 1'b0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (is_sync) begin
            lock_cnt_nxt = 8'd1;
            tmo_cnt_nxt  = 16'd0;
            if (LOCK_LAST == 8'd1) begin
              state_nxt    = ST_LOCKED;
              slip_cnt_nxt = '0;
            end else begin
              state_nxt = ST_CONFIRM;
            end
          end else begin
            // Slip only the lanes whose nibble is off target
            for (int k = 0; k < 4; k++) begin
              bitslip_nxt[k]  = (w[4*k +: 4] != SYNC_WORD[4*k +: 4]);
              slip_cnt_nxt[k] = slip_cnt[k] + {3'd0, bitslip_nxt[k]};
              slip_limit      = slip_limit | (slip_cnt_nxt[k] == 4'd9);
            end
            if (slip_limit) begin
              align_err_nxt = 1'b1;
              slip_cnt_nxt  = '0;
            end else begin
              align_err_nxt = align_err_o;
            end
            wait_cnt_nxt = 4'd0;
            state_nxt    = ST_SLIP;
          end
        end
        ST_SLIP: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt_nxt = 4'd0;
            state_nxt    = ST_SEARCH;
          end else begin
            wait_cnt_nxt = wait_cnt + 4'd1;
          end
        end
        ST_CONFIRM: begin
          if (!is_sync) begin
            state_nxt = ST_SEARCH;
          end else if (lock_cnt + 8'd1 == LOCK_LAST) begin
            state_nxt    = ST_LOCKED;
            slip_cnt_nxt = '0;
            tmo_cnt_nxt  = 16'd0;
          end else begin
            lock_cnt_nxt = lock_cnt + 8'd1;
          end
        end
        ST_LOCKED: begin
          if (!is_sync && (tmo_cnt + 16'd1 == TMO_LAST)) begin
            state_nxt   = ST_SEARCH;
            tmo_cnt_nxt = 16'd0;
          end else begin
            if (is_cmd) begin
              cmd_valid_nxt = 1'b1;
              cmd_nxt       = w[15:11];
              cmd_dat_nxt   = w[7:0];
            end else begin
              data_valid_nxt = 1'b1;
              corr_nxt       = w[15:11];
              power_nxt      = w[10:0];
            end
            sync_nxt    = is_sync;
            tmo_cnt_nxt = is_sync ? 16'd0 : tmo_cnt + 16'd1;
          end
        end
        default: begin
          state_nxt = ST_SEARCH;
        end
      endcase
    end

    locked_nxt = (state_nxt == ST_LOCKED);
  end

  // State, counters and registered outputs
  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_SEARCH;
      slip_cnt     <= '0;
      wait_cnt     <= 4'd0;
      lock_cnt     <= 8'd0;
      tmo_cnt      <= 16'd0;
      train_d      <= 1'b0;
      locked_o     <= 1'b0;
      bitslip_o    <= 4'd0;
      align_err_o  <= 1'b0;
      sync_o       <= 1'b0;
      cmd_valid_o  <= 1'b0;
      cmd_o        <= 5'd0;
      cmd_dat_o    <= 8'd0;
      data_valid_o <= 1'b0;
      corr_o       <= 5'd0;
      power_o      <= 11'd0;
    end else begin
      state        <= state_nxt;
      slip_cnt     <= slip_cnt_nxt;
      wait_cnt     <= wait_cnt_nxt;
      lock_cnt     <= lock_cnt_nxt;
      tmo_cnt      <= tmo_cnt_nxt;
      train_d      <= train_i;
      locked_o     <= locked_nxt;
      bitslip_o    <= bitslip_nxt;
      align_err_o  <= align_err_nxt;
      sync_o       <= sync_nxt;
      cmd_valid_o  <= cmd_valid_nxt;
      cmd_o        <= cmd_nxt;
      cmd_dat_o    <= cmd_dat_nxt;
      data_valid_o <= data_valid_nxt;
      corr_o       <= corr_nxt;
      power_o      <= power_nxt;
    end
  end

endmodule
